// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode map, control bundle and stage state shared by the decode stage
package decode_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEXT  = 5'b10110;

    typedef struct packed {
        logic jp;
        logic br;
        logic dmwe;
        logic rwd;
        logic rdst;
        logic rwe;
        logic alub;
        logic aluop;
        logic illegal;
    } ctrlBundle;

    typedef enum logic {
        RUN,
        BUBBLE
    } stageState;

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// rtl/decode_ctrl_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface decode_ctrl_stage_if #(
    parameter int INSN_W = 32,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic [INSN_W-1:0] in_insn;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [INSN_W-1:0] out_insn;
    logic              out_jp;
    logic              out_br;
    logic              out_dmwe;
    logic              out_rwd;
    logic              out_rdst;
    logic              out_rwe;
    logic              out_alub;
    logic              out_aluop;
    logic              out_illegal;
    logic [CNT_W-1:0]  stall_cnt;

    modport slave (
        input  in_valid, in_insn, flush, out_ready,
        output in_ready, out_valid, out_insn,
        output out_jp, out_br, out_dmwe, out_rwd, out_rdst, out_rwe, out_alub, out_aluop,
        output out_illegal, stall_cnt
    );

    modport master (
        output in_valid, in_insn, flush, out_ready,
        input  in_ready, out_valid, out_insn,
        input  out_jp, out_br, out_dmwe, out_rwd, out_rdst, out_rwe, out_alub, out_aluop,
        input  out_illegal, stall_cnt
    );
endinterface

// File: rtl/decode_ctrl_stage_opcode_decode.sv
// rtl/decode_ctrl_stage_opcode_decode.sv - combinational opcode to control bundle; DECODE_ILLEGAL_TRAP_EN flags undefined opcodes
module opcode_decode
    import decode_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] opcode,
    output ctrlBundle        ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OPC_W'(OP_RTYPE): ctrl.rwe = 1'b1;
            OPC_W'(OP_J): begin
                ctrl.jp   = 1'b1;
                ctrl.rdst = 1'b1;
            end
            OPC_W'(OP_BNE), OPC_W'(OP_BLT): begin
                ctrl.br    = 1'b1;
                ctrl.aluop = 1'b1;
                ctrl.rdst  = 1'b1;
            end
            OPC_W'(OP_JAL), OPC_W'(OP_SETX): begin
                ctrl.jp   = 1'b1;
                ctrl.rwe  = 1'b1;
                ctrl.rdst = 1'b1;
            end
            OPC_W'(OP_JR), OPC_W'(OP_BEXT): begin
                ctrl.jp   = 1'b1;
                ctrl.rdst = 1'b1;
            end
            OPC_W'(OP_ADDI): begin
                ctrl.rwe  = 1'b1;
                ctrl.alub = 1'b1;
                ctrl.rdst = 1'b1;
            end
            OPC_W'(OP_SW): begin
                ctrl.dmwe = 1'b1;
                ctrl.alub = 1'b1;
                ctrl.rdst = 1'b1;
            end
            OPC_W'(OP_LW): begin
                ctrl.rwd  = 1'b1;
                ctrl.rwe  = 1'b1;
                ctrl.alub = 1'b1;
                ctrl.rdst = 1'b1;
            end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                ctrl.illegal = 1'b1;
`else
                // Undefined opcodes travel down the pipe as plain NOPs.
                ctrl.illegal = 1'b0;
`endif
            end
        endcase
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// rtl/decode_ctrl_stage.sv - registered decode stage with load-use interlock, flush and stall counter (DECODE_ILLEGAL_TRAP_EN enables out_illegal)
module decode_ctrl_stage
    import decode_pkg::*;
#(
    parameter int INSN_W = 32,
    parameter int OPC_W  = 5,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    decode_ctrl_stage_if.slave  bus
);

    localparam int RD_LSB = INSN_W - OPC_W - REG_W;
    localparam int RS_LSB = RD_LSB - REG_W;
    localparam int RT_LSB = RS_LSB - REG_W;

    ctrlBundle         decCtrl;
    ctrlBundle         outCtrl;
    logic [INSN_W-1:0] outInsn;
    logic              outValid;
    logic [CNT_W-1:0]  stallCnt;
    stageState         state;
    stageState         stateNext;
    logic              hazard;
    logic              inReady;
    logic              load;
    logic [REG_W-1:0]  outRd;
    logic [REG_W-1:0]  inRs;
    logic [REG_W-1:0]  inRt;

    opcode_decode #(.OPC_W(OPC_W)) u_opcode_decode (
        .opcode (bus.in_insn[INSN_W-1 -: OPC_W]),
        .ctrl   (decCtrl)
    );

    assign outRd = outInsn[RD_LSB +: REG_W];
    assign inRs  = bus.in_insn[RS_LSB +: REG_W];
    assign inRt  = bus.in_insn[RT_LSB +: REG_W];

    // A held load whose destination feeds the incoming instruction must drain first.
    always_comb begin
        hazard = outValid & outCtrl.rwd & (outRd != '0) &
                 ((outRd == inRs) | (outRd == inRt)) & bus.in_valid;
        if (bus.flush) begin
            inReady = 1'b1;
        end else if (hazard) begin
            inReady = 1'b0;
        end else begin
            inReady = ~outValid | bus.out_ready;
        end
        load = ~bus.flush & ~hazard & bus.in_valid & inReady;
    end

    always_comb begin
        stateNext = state;
        case (state)
            RUN:     if (hazard && bus.out_ready) stateNext = BUBBLE;
            BUBBLE:  stateNext = RUN;
            default: stateNext = RUN;
        endcase
        if (bus.flush) begin
            stateNext = RUN;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            outValid <= 1'b0;
            outInsn  <= '0;
            outCtrl  <= '0;
            stallCnt <= '0;
        end else begin
            state <= stateNext;
            if (bus.flush) begin
                outValid <= 1'b0;
            end else if (hazard) begin
                if (bus.out_ready) begin
                    outValid <= 1'b0;
                end
                if (stallCnt != '1) begin
                    stallCnt <= stallCnt + CNT_W'(1);
                end
            end else if (load) begin
                outValid <= 1'b1;
                outInsn  <= bus.in_insn;
                outCtrl  <= decCtrl;
            end else if (bus.out_ready) begin
                outValid <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = inReady;
    assign bus.out_valid   = outValid;
    assign bus.out_insn    = outInsn;
    assign bus.out_jp      = outCtrl.jp;
    assign bus.out_br      = outCtrl.br;
    assign bus.out_dmwe    = outCtrl.dmwe;
    assign bus.out_rwd     = outCtrl.rwd;
    assign bus.out_rdst    = outCtrl.rdst;
    assign bus.out_rwe     = outCtrl.rwe;
    assign bus.out_alub    = outCtrl.alub;
    assign bus.out_aluop   = outCtrl.aluop;
    assign bus.out_illegal = outCtrl.illegal;
    assign bus.stall_cnt   = stallCnt;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb/tb_decode_ctrl_stage.sv - self-checking bench for decode_ctrl_stage against a behavioural pipeline model
module tb_decode_ctrl_stage;

    localparam int INSN_W    = 32;
    localparam int OPC_W     = 5;
    localparam int REG_W     = 5;
    localparam int CNT_W     = 6;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    decode_ctrl_stage_if #(.INSN_W(INSN_W), .CNT_W(CNT_W)) bus ();

    decode_ctrl_stage #(
        .INSN_W (INSN_W),
        .OPC_W  (OPC_W),
        .REG_W  (REG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int nCmp  = 0;
    int nFail = 0;

    bit          mValid;
    logic [31:0] mInsn;
    int          mStall;
    bit          expReady;
    bit          obsReady;

    function automatic logic [4:0] fRd(input logic [31:0] x); return x[26:22]; endfunction
    function automatic logic [4:0] fRs(input logic [31:0] x); return x[21:17]; endfunction
    function automatic logic [4:0] fRt(input logic [31:0] x); return x[16:12]; endfunction

    function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt);
        logic [11:0] tail;
        tail = 12'($urandom);
        return {5'(op), 5'(rd), 5'(rs), 5'(rt), tail};
    endfunction

    // {jp,br,dmwe,rwd,rdst,rwe,alub,aluop,illegal} from opcode-set membership
    function automatic logic [8:0] refCtl(input logic [31:0] insn);
        logic [4:0] op;
        bit known;
        logic [8:0] r;
        op    = insn[31:27];
        known = (op <= 5'd8) || op == 5'd21 || op == 5'd22;
        r[8]  = op inside {5'd1, 5'd3, 5'd4, 5'd21, 5'd22};
        r[7]  = op inside {5'd2, 5'd6};
        r[6]  = (op == 5'd7);
        r[5]  = (op == 5'd8);
        r[4]  = known && op != 5'd0;
        r[3]  = op inside {5'd0, 5'd5, 5'd8, 5'd3, 5'd21};
        r[2]  = op inside {5'd5, 5'd8, 5'd7};
        r[1]  = op inside {5'd2, 5'd6};
`ifdef DECODE_ILLEGAL_TRAP_EN
        r[0]  = !known;
`else
        r[0]  = 1'b0;
`endif
        return r;
    endfunction

    function automatic logic [8:0] obsCtl();
        return {bus.out_jp, bus.out_br, bus.out_dmwe, bus.out_rwd, bus.out_rdst,
                bus.out_rwe, bus.out_alub, bus.out_aluop, bus.out_illegal};
    endfunction

    // One clock: drive inputs, sample in_ready before the edge, advance the model after it.
    task automatic step(input bit inV, input logic [31:0] insn, input bit outR, input bit fl);
        bit haz;
        logic [8:0] c;
        @(negedge clock);
        bus.in_valid  = inV;
        bus.in_insn   = insn;
        bus.out_ready = outR;
        bus.flush     = fl;
        #1;
        obsReady = bus.in_ready;
        c   = refCtl(mInsn);
        haz = mValid && c[5] && fRd(mInsn) != 5'd0 &&
              (fRd(mInsn) == fRs(insn) || fRd(mInsn) == fRt(insn)) && inV;
        expReady = fl ? 1'b1 : (haz ? 1'b0 : (!mValid || outR));
        @(posedge clock);
        #1;
        if (fl) begin
            mValid = 1'b0;
        end else if (haz) begin
            if (outR) mValid = 1'b0;
            if (mStall < STALL_MAX) mStall++;
        end else if (inV && expReady) begin
            mValid = 1'b1;
            mInsn  = insn;
        end else if (outR) begin
            mValid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_insn  = mk(5, 1, 2, 3);
        bus.out_ready = 1'b1;
        bus.flush    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        nCmp++; if (bus.out_valid !== 1'b0) begin nFail++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        nCmp++; if (bus.stall_cnt !== '0) begin nFail++; $display("FAIL reset_stall_cnt got=%0d exp=0", bus.stall_cnt); end
        nCmp++; if (bus.out_insn !== '0 || obsCtl() !== 9'd0) begin nFail++; $display("FAIL reset_payload insn=%h ctl=%b exp=0", bus.out_insn, obsCtl()); end
        @(negedge clock);
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;
        mValid = 1'b0; mInsn = '0; mStall = 0;
        #1;
        nCmp++; if (bus.in_ready !== 1'b1) begin nFail++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    endtask

    task automatic test_stream();
        logic [31:0] insns [3];
        logic [8:0]  want  [3];
        insns[0] = mk(5, 1, 2, 3);  want[0] = 9'b000011100;
        insns[1] = mk(7, 4, 1, 2);  want[1] = 9'b001010100;
        insns[2] = mk(1, 0, 0, 0);  want[2] = 9'b100010000;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, insns[i], 1'b1, 1'b0);
            nCmp++; if (bus.out_valid !== 1'b1 || bus.out_insn !== insns[i]) begin nFail++; $display("FAIL stream_insn%0d valid=%0b got=%h exp=%h", i, bus.out_valid, bus.out_insn, insns[i]); end
            nCmp++; if (obsCtl() !== want[i]) begin nFail++; $display("FAIL stream_ctl%0d got=%b exp=%b", i, obsCtl(), want[i]); end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        nCmp++; if (bus.out_valid !== 1'b0) begin nFail++; $display("FAIL stream_drain got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_load_use();
        logic [31:0] lw, add, lw0, add0;
        lw   = mk(8, 3, 1, 2);
        add  = mk(0, 4, 3, 5);
        lw0  = mk(8, 0, 1, 2);
        add0 = mk(0, 4, 0, 5);
        step(1'b1, lw, 1'b1, 1'b0);
        step(1'b1, add, 1'b1, 1'b0);
        nCmp++; if (obsReady !== 1'b0) begin nFail++; $display("FAIL loaduse_stall_ready got=%0b exp=0", obsReady); end
        nCmp++; if (bus.out_valid !== 1'b0) begin nFail++; $display("FAIL loaduse_bubble got=%0b exp=0", bus.out_valid); end
        nCmp++; if (bus.stall_cnt !== CNT_W'(1)) begin nFail++; $display("FAIL loaduse_stall_cnt got=%0d exp=1", bus.stall_cnt); end
        step(1'b1, add, 1'b1, 1'b0);
        nCmp++; if (obsReady !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_insn !== add) begin nFail++; $display("FAIL loaduse_resume ready=%0b valid=%0b got=%h exp=%h", obsReady, bus.out_valid, bus.out_insn, add); end
        step(1'b1, lw0, 1'b1, 1'b0);
        step(1'b1, add0, 1'b1, 1'b0);
        nCmp++; if (obsReady !== 1'b1 || bus.out_insn !== add0 || bus.stall_cnt !== CNT_W'(1)) begin nFail++; $display("FAIL loaduse_r0 ready=%0b got=%h exp=%h stall=%0d exp=1", obsReady, bus.out_insn, add0, bus.stall_cnt); end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        step(1'b1, mk(5, 1, 2, 3), 1'b1, 1'b0);
        step(1'b1, mk(5, 2, 0, 0), 1'b0, 1'b1);
        nCmp++; if (obsReady !== 1'b1 || bus.out_valid !== 1'b0) begin nFail++; $display("FAIL flush_kill ready=%0b valid=%0b exp ready=1 valid=0", obsReady, bus.out_valid); end
        step(1'b0, '0, 1'b1, 1'b0);
        nCmp++; if (bus.out_valid !== 1'b0) begin nFail++; $display("FAIL flush_dropped got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        a = mk(5, 6, 1, 1);
        step(1'b1, a, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(7, 2, 3, 4), 1'b0, 1'b0);
            nCmp++; if (obsReady !== 1'b0 || bus.out_valid !== 1'b1) begin nFail++; $display("FAIL bp_hold%0d ready=%0b valid=%0b exp ready=0 valid=1", i, obsReady, bus.out_valid); end
            nCmp++; if (bus.out_insn !== a || obsCtl() !== refCtl(a)) begin nFail++; $display("FAIL bp_stable%0d got=%h/%b exp=%h/%b", i, bus.out_insn, obsCtl(), a, refCtl(a)); end
        end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_illegal();
        logic [31:0] u;
        logic [8:0]  want;
`ifdef DECODE_ILLEGAL_TRAP_EN
        want = 9'b000000001;
`else
        want = 9'b000000000;
`endif
        for (int i = 0; i < 2; i++) begin
            u = (i == 0) ? mk(31, 1, 2, 3) : mk(20, 5, 6, 7);
            step(1'b1, u, 1'b1, 1'b0);
            nCmp++; if (bus.out_valid !== 1'b1 || obsCtl() !== want) begin nFail++; $display("FAIL illegal%0d valid=%0b ctl=%b exp=%b", i, bus.out_valid, obsCtl(), want); end
        end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int ops [13];
        ops = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22, 31, 9};
        for (int i = 0; i < 400; i++) begin
            int op;
            op = (($urandom % 3) == 0) ? 8 : ops[$urandom_range(0, 12)];
            step(($urandom % 5) != 0,
                 mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
                 ($urandom % 4) != 0, ($urandom % 12) == 0);
            nCmp++; if (obsReady !== expReady) begin nFail++; $display("FAIL rand_in_ready@%0d got=%0b exp=%0b", i, obsReady, expReady); end
            nCmp++; if (bus.out_valid !== mValid || bus.stall_cnt !== CNT_W'(mStall)) begin nFail++; $display("FAIL rand_state@%0d valid=%0b exp=%0b stall=%0d exp=%0d", i, bus.out_valid, mValid, bus.stall_cnt, mStall); end
            if (mValid) begin
                nCmp++; if (bus.out_insn !== mInsn || obsCtl() !== refCtl(mInsn)) begin nFail++; $display("FAIL rand_payload@%0d got=%h/%b exp=%h/%b", i, bus.out_insn, obsCtl(), mInsn, refCtl(mInsn)); end
            end
        end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_saturation();
        logic [31:0] lw, user;
        lw   = mk(8, 7, 1, 1);
        user = mk(0, 1, 7, 2);
        step(1'b1, lw, 1'b1, 1'b0);
        repeat (STALL_MAX + 4) step(1'b1, user, 1'b0, 1'b0);
        nCmp++; if (bus.stall_cnt !== CNT_W'(STALL_MAX)) begin nFail++; $display("FAIL sat_cnt got=%0d exp=%0d", bus.stall_cnt, STALL_MAX); end
        nCmp++; if (obsReady !== 1'b0 || bus.out_insn !== lw) begin nFail++; $display("FAIL sat_hold ready=%0b got=%h exp=%h", obsReady, bus.out_insn, lw); end
        step(1'b1, user, 1'b1, 1'b0);
        step(1'b1, user, 1'b1, 1'b0);
        nCmp++; if (bus.out_insn !== user || bus.stall_cnt !== CNT_W'(STALL_MAX)) begin nFail++; $display("FAIL sat_after got=%h exp=%h stall=%0d exp=%0d", bus.out_insn, user, bus.stall_cnt, STALL_MAX); end
    endtask

    task automatic test_reset_midop();
        step(1'b1, mk(5, 1, 2, 3), 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        nCmp++; if (bus.out_valid !== 1'b0 || bus.stall_cnt !== '0) begin nFail++; $display("FAIL midop_reset valid=%0b stall=%0d exp 0/0", bus.out_valid, bus.stall_cnt); end
        @(negedge clock);
        reset_n = 1'b1;
        mValid = 1'b0; mStall = 0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_insn   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        mValid = 1'b0; mInsn = '0; mStall = 0;
        test_reset();
        test_stream();
        test_load_use();
        test_flush();
        test_backpressure();
        test_illegal();
        test_random();
        test_saturation();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
